// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// and a small {pc, inst} FIFO toward decode with redirect-driven flush.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int              AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_t;

   state_t          state_reg, state_next;
   logic [31:0]     pc_reg, pc_next;
   logic [31:0]     req_pc_reg;
   logic            started_reg;
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     count_reg, count_next;
   logic [31:0]     entry_pc   [FIFO_DEPTH];
   logic [31:0]     entry_inst [FIFO_DEPTH];
   logic [31:0]     redirect_target;
   logic            req_fire, push, pop;

   // started_reg keeps the request low until the first edge after reset release
   assign imem_req_valid  = started_reg && (state_reg == ST_REQ) &&
                            (count_reg < DEPTH_C) && !redirect;
   assign imem_req_addr   = pc_reg;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign push       = (state_reg == ST_WAIT) && imem_rsp_valid && !redirect;
   assign inst_valid = (count_reg != '0);
   assign pop        = inst_valid && inst_ready && !redirect;
   assign inst       = entry_inst[rd_ptr_reg];
   assign inst_pc    = entry_pc[rd_ptr_reg];

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      count_next = count_reg;
      case (state_reg)
         ST_REQ:  if (req_fire) state_next = ST_WAIT;
         ST_WAIT: begin
            if (imem_rsp_valid)  state_next = ST_REQ;
            else if (redirect)   state_next = ST_DROP;
         end
         ST_DROP: if (imem_rsp_valid) state_next = ST_REQ;
         default: state_next = ST_REQ;
      endcase
      if (redirect)      pc_next = redirect_target;
      else if (req_fire) pc_next = pc_reg + 32'd4;
      if (redirect)             count_next = '0;
      else if (push && !pop)    count_next = count_reg + 1'b1;
      else if (!push && pop)    count_next = count_reg - 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= ST_REQ;
         pc_reg      <= RESET_PC;
         req_pc_reg  <= '0;
         started_reg <= 1'b0;
         count_reg   <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         started_reg <= 1'b1;
         count_reg   <= count_next;
         if (req_fire) req_pc_reg <= pc_reg;
         if (redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [31:0] pc_q;
      logic [31:0] inst_q;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            pc_q   <= '0;
            inst_q <= '0;
         end else if (push && (wr_ptr_reg == AW'(gi))) begin
            pc_q   <= req_pc_reg;
            inst_q <= imem_rsp_data;
         end
      end
      assign entry_pc[gi]   = pc_q;
      assign entry_inst[gi] = inst_q;
   end

endmodule
